conv_neuron_mac: RTL

- Parametrised, sequential successor to the single-cycle 4-tap convolution neuron.
- Computes one dot product of `NUM_TAPS` unsigned pixels with `NUM_TAPS` signed kernel weights, using `LANES` multipliers per cycle over `NUM_TAPS/LANES` beats.
- Adds a stored kernel register, valid/ready handshakes on input and output, arithmetic right-shift scaling, saturation and optional ReLU.
- Sits between the pixel window buffer and the activation/output stage of the CNN datapath.

---
 rtl/conv_neuron_pkg.sv | 21 ++
 rtl/conv_mac_lane.sv | 23 ++
 rtl/conv_neuron_mac.sv | 143 ++++++++++++++
 3 files changed

// File: rtl/conv_neuron_pkg.sv
// Shared types and the saturation/ReLU helper for the sequential convolution neuron.
package conv_neuron_pkg;

  typedef enum logic [1:0] {IDLE, MAC, DONE} state_t;

  // Wide enough for any accumulator width this block is instantiated with.
  localparam int unsigned SAT_W = 64;

  function automatic logic signed [SAT_W-1:0] sat_relu(
    input logic signed [SAT_W-1:0] val,
    input logic                    relu,
    input logic signed [SAT_W-1:0] lo,
    input logic signed [SAT_W-1:0] hi
  );
    if (relu && (val < 0)) return '0;
    if (val > hi) return hi;
    if (val < lo) return lo;
    return val;
  endfunction

endpackage

// File: rtl/conv_mac_lane.sv
// Combinational sum of LANES unsigned-pixel by signed-weight products at accumulator width.
module conv_mac_lane #(
  parameter int unsigned LANES  = 1,
  parameter int unsigned DATA_W = 8,
  parameter int unsigned COEF_W = 8,
  parameter int unsigned ACC_W  = 19
) (
  input  logic [LANES*DATA_W-1:0] pix,
  input  logic [LANES*COEF_W-1:0] coef,
  output logic signed [ACC_W-1:0] sum
);

  logic signed [DATA_W+COEF_W:0] prod [LANES];

  always_comb begin
    sum = '0;
    for (int i = 0; i < LANES; i++) begin
      prod[i] = $signed({1'b0, pix[i*DATA_W +: DATA_W]}) * $signed(coef[i*COEF_W +: COEF_W]);
      sum     = sum + ACC_W'(prod[i]);
    end
  end

endmodule

// File: rtl/conv_neuron_mac.sv
// Multi-beat convolution neuron: stored kernel, valid/ready handshakes, shift, saturate, ReLU.
module conv_neuron_mac
  import conv_neuron_pkg::*;
#(
  parameter int unsigned NUM_TAPS = 4,
  parameter int unsigned LANES    = 1,
  parameter int unsigned DATA_W   = 8,
  parameter int unsigned COEF_W   = 8,
  parameter int unsigned OUT_W    = 8,
  parameter int unsigned SHIFT    = 0
) (
  input  logic                               clk,
  input  logic                               rst_n,
  input  logic                               kernel_we,
  input  logic [NUM_TAPS*COEF_W-1:0]         kernel_in,
  input  logic                               in_valid,
  output logic                               in_ready,
  input  logic [NUM_TAPS-1:0][DATA_W-1:0]    pixels,
  input  logic                               relu_en,
  output logic                               out_valid,
  input  logic                               out_ready,
  output logic [OUT_W-1:0]                   conv_result,
  output logic                               kernel_drop
);

  localparam int unsigned BEATS  = NUM_TAPS / LANES;
  localparam int unsigned BEAT_W = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam int unsigned ACC_W  = DATA_W + COEF_W + 1 + $clog2(NUM_TAPS);
  localparam logic signed [SAT_W-1:0] OUT_MAX = {{(SAT_W-OUT_W+1){1'b0}}, {(OUT_W-1){1'b1}}};
  localparam logic signed [SAT_W-1:0] OUT_MIN = ~OUT_MAX;

  if ((NUM_TAPS % LANES) != 0) begin : g_bad_lanes
    $error("NUM_TAPS must be a multiple of LANES");
  end
  if (SHIFT >= ACC_W) begin : g_bad_shift
    $error("SHIFT must be smaller than the accumulator width");
  end

  state_t                      state_q, state_d;
  logic [BEAT_W-1:0]           beat_q, beat_d;
  logic signed [ACC_W-1:0]     acc_q, acc_d;
  logic [NUM_TAPS*COEF_W-1:0]  kernel_q, kernel_d;
  logic [NUM_TAPS*DATA_W-1:0]  pix_q, pix_d;
  logic                        relu_q, relu_d;
  logic [OUT_W-1:0]            result_q, result_d;
  logic                        valid_q, valid_d;
  logic                        drop_q, drop_d;

  logic signed [ACC_W-1:0]     lane_sum;
  logic signed [ACC_W-1:0]     acc_sum;
  logic signed [ACC_W-1:0]     shifted;
  logic signed [SAT_W-1:0]     sat_val;
  logic                        unused_sat;

  conv_mac_lane #(
    .LANES  (LANES),
    .DATA_W (DATA_W),
    .COEF_W (COEF_W),
    .ACC_W  (ACC_W)
  ) u_lane (
    .pix  (pix_q[beat_q * (LANES*DATA_W) +: LANES*DATA_W]),
    .coef (kernel_q[beat_q * (LANES*COEF_W) +: LANES*COEF_W]),
    .sum  (lane_sum)
  );

  assign acc_sum    = acc_q + lane_sum;
  assign shifted    = acc_sum >>> SHIFT;
  assign sat_val    = sat_relu(SAT_W'(shifted), relu_q, OUT_MIN, OUT_MAX);
  assign unused_sat = ^sat_val[SAT_W-1:OUT_W];

  always_comb begin
    state_d  = state_q;
    beat_d   = beat_q;
    acc_d    = acc_q;
    kernel_d = kernel_q;
    pix_d    = pix_q;
    relu_d   = relu_q;
    result_d = result_q;
    valid_d  = valid_q;
    drop_d   = drop_q;
    unique case (state_q)
      IDLE: begin
        // Kernel is written first so a same-cycle vector computes with it.
        if (kernel_we) kernel_d = kernel_in;
        if (in_valid) begin
          pix_d   = pixels;
          relu_d  = relu_en;
          acc_d   = '0;
          beat_d  = '0;
          state_d = MAC;
        end
      end
      MAC: begin
        if (kernel_we) drop_d = 1'b1;
        acc_d  = acc_sum;
        beat_d = beat_q + 1'b1;
        if (beat_q == BEAT_W'(BEATS - 1)) begin
          result_d = sat_val[OUT_W-1:0];
          valid_d  = 1'b1;
          state_d  = DONE;
        end
      end
      DONE: begin
        if (kernel_we) drop_d = 1'b1;
        if (out_ready) begin
          valid_d = 1'b0;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      beat_q   <= '0;
      acc_q    <= '0;
      kernel_q <= '0;
      pix_q    <= '0;
      relu_q   <= 1'b0;
      result_q <= '0;
      valid_q  <= 1'b0;
      drop_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      beat_q   <= beat_d;
      acc_q    <= acc_d;
      kernel_q <= kernel_d;
      pix_q    <= pix_d;
      relu_q   <= relu_d;
      result_q <= result_d;
      valid_q  <= valid_d;
      drop_q   <= drop_d;
    end
  end

  assign in_ready    = (state_q == IDLE);
  assign out_valid   = valid_q;
  assign conv_result = result_q;
  assign kernel_drop = drop_q;

endmodule
